// File: rtl/sign_narrow_32to15.sv
// Narrows a signed 32-bit immediate to 15 bits through a one-entry output buffer, counting overflows.
// Optional build macro SIGN_NARROW_SATURATE_EN: clamp out-of-range words instead of truncating them.
module sign_narrow_32to15 #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      imm32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [14:0]      imm15,
  output logic             ovf,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int unsigned IMM_W = 15;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IMM_W-1:0]   imm15_q, imm15_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept_c;
  logic               in_range_c;
  logic [IMM_W-1:0]   narrowed_c;

  // Word fits in 15 bits when the upper 18 bits are a pure sign extension.
  assign in_range_c = (&imm32[31:14]) | (~|imm32[31:14]);
  assign in_ready   = (state_q == EMPTY) | out_ready;
  assign accept_c   = in_valid & in_ready;

  always_comb begin
    narrowed_c = imm32[IMM_W-1:0];
`ifdef SIGN_NARROW_SATURATE_EN
    if (!in_range_c) begin
      narrowed_c = imm32[31] ? 15'h4000 : 15'h3FFF;
    end
`endif
  end

  // Next-state, buffer load and overflow counter.
  always_comb begin
    state_d = state_q;
    imm15_d = imm15_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      EMPTY: begin
        if (accept_c) state_d = FULL;
      end
      FULL: begin
        if (accept_c)       state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (accept_c) begin
      imm15_d = narrowed_c;
      ovf_d   = ~in_range_c;
    end

    // Clear wins over a same-edge overflow; counter saturates at all-ones.
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (accept_c && !in_range_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      imm15_q <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      imm15_q <= imm15_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign imm15     = imm15_q;
  assign ovf       = ovf_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_sign_narrow_32to15.sv
// Randomised and directed bench for sign_narrow_32to15 against an arithmetic reference model.
module tb_sign_narrow_32to15;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] imm32;
  logic        out_ready;
  logic        clr_cnt;
  logic        in_ready, in_ready2;
  logic        out_valid, out_valid2;
  logic [14:0] imm15, imm15_2;
  logic        ovf, ovf2;
  logic [15:0] ovf_cnt;
  logic [1:0]  ovf_cnt2;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_full;
  logic [14:0] m_imm;
  bit          m_ovf;
  int          m_cnt16;
  int          m_cnt2;

  sign_narrow_32to15 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .imm32(imm32),
    .out_valid(out_valid), .out_ready(out_ready), .imm15(imm15), .ovf(ovf),
    .clr_cnt(clr_cnt), .ovf_cnt(ovf_cnt)
  );

  sign_narrow_32to15 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .imm32(imm32),
    .out_valid(out_valid2), .out_ready(out_ready), .imm15(imm15_2), .ovf(ovf2),
    .clr_cnt(clr_cnt), .ovf_cnt(ovf_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] w);
    int s;
    s = $signed(w);
    return (s >= -16384) && (s <= 16383);
  endfunction

  function automatic logic [14:0] expect_imm(input logic [31:0] w);
    logic [14:0] r;
    r = w[14:0];
`ifdef SIGN_NARROW_SATURATE_EN
    if (!in_range(w)) r = ($signed(w) > 0) ? 15'h3FFF : 15'h4000;
`endif
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_full));
    chk({tag, ".out_valid2"}, 32'(out_valid2), 32'(m_full));
    chk({tag, ".ovf_cnt"}, 32'(ovf_cnt), 32'(m_cnt16));
    chk({tag, ".ovf_cnt2"}, 32'(ovf_cnt2), 32'(m_cnt2));
    if (m_full) begin
      chk({tag, ".imm15"}, 32'(imm15), 32'(m_imm));
      chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
      chk({tag, ".imm15_2"}, 32'(imm15_2), 32'(m_imm));
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model and DUT, compare outputs.
  task automatic cyc(input string tag, input bit vld, input logic [31:0] w,
                     input bit ordy, input bit clr);
    bit acc;
    in_valid  = vld;
    imm32     = w;
    out_ready = ordy;
    clr_cnt   = clr;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_full || ordy));
    acc = vld && (!m_full || ordy);
    if (acc) begin
      m_full = 1'b1;
      m_imm  = expect_imm(w);
      m_ovf  = !in_range(w);
    end else if (ordy) begin
      m_full = 1'b0;
    end
    if (clr) begin
      m_cnt16 = 0;
      m_cnt2  = 0;
    end else if (acc && !in_range(w)) begin
      m_cnt16 = (m_cnt16 + 1 > 65535) ? 65535 : m_cnt16 + 1;
      m_cnt2  = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [31:0] rand_word();
    int unsigned sel;
    logic [31:0] r;
    sel = $urandom_range(0, 3);
    r   = $urandom;
    case (sel)
      0: r = {{17{r[14]}}, r[14:0]};
      1: r = r;
      2: r = (r[0]) ? 32'h0000_3FFF : 32'hFFFF_C000;
      default: r = (r[0]) ? 32'h0000_4000 : 32'hFFFF_BFFF;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] w;
    rst = 1'b1; in_valid = 1'b0; imm32 = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    m_full = 1'b0; m_imm = '0; m_ovf = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
    #2;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.imm15", 32'(imm15), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    check_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'd1);

    // Most negative in-range value
    cyc("neg_edge", 1'b1, 32'hFFFF_C000, 1'b1, 1'b0);
    chk("neg_edge.imm15_const", 32'(imm15), 32'h4000);
    chk("neg_edge.ovf_const", 32'(ovf), 32'd0);
    // Just above positive range
    cyc("pos_ovf", 1'b1, 32'h0000_4000, 1'b1, 1'b0);
    chk("pos_ovf.ovf_const", 32'(ovf), 32'd1);
    chk("pos_ovf.cnt_const", 32'(ovf_cnt), 32'd1);
`ifdef SIGN_NARROW_SATURATE_EN
    chk("pos_ovf.imm15_const", 32'(imm15), 32'h3FFF);
`else
    chk("pos_ovf.imm15_const", 32'(imm15), 32'h4000);
`endif
    cyc("drain0", 1'b0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: three words offered while the consumer stalls
    cyc("bp1", 1'b1, 32'h0000_0123, 1'b0, 1'b0);
    cyc("bp2", 1'b1, 32'h0000_0456, 1'b0, 1'b0);
    cyc("bp3", 1'b1, 32'h0000_0789, 1'b0, 1'b0);
    chk("bp.hold_first", 32'(imm15), 32'h0123);
    cyc("bp_drain", 1'b0, 32'h0, 1'b1, 1'b0);

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      cyc("stream", 1'b1, rand_word(), 1'b1, 1'b0);
    end
    cyc("drain1", 1'b0, 32'h0, 1'b1, 1'b0);

    // Counter saturation on the narrow-counter instance, then clear priority
    cyc("clr0", 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      w = (i % 2 == 0) ? ((w & 32'h3FFF_FFFF) | 32'h4000_0000) : ((w & 32'h7FFF_FFFF) | 32'h8000_0000);
      cyc("sat", 1'b1, w, 1'b1, 1'b0);
    end
    chk("sat.cnt2_const", 32'(ovf_cnt2), 32'd3);
    cyc("clr_prio", 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    chk("clr_prio.cnt_const", 32'(ovf_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cyc("rand", 1'($urandom_range(0, 3) != 0), rand_word(),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset mid-cycle while holding a result
    cyc("pre_rst", 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    m_full = 1'b0; m_imm = '0; m_ovf = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.imm15", 32'(imm15), 32'd0);
    chk("async_rst.ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("async_rst.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);
    cyc("post_rst_idle", 1'b0, 32'h0, 1'b0, 1'b0);
    cyc("post_rst_new", 1'b1, 32'h0000_1234, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
